// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: sequential turn-signal and hazard lamp controller.
//
// Ports:
//   CLOCK_50    in   single clock; all state changes on its rising edge
//   RESET       in   asynchronous, active-high reset
//   SW_LEFT     in   left turn request (asynchronous level)
//   SW_RIGHT    in   right turn request (asynchronous level)
//   SW_HAZARD   in   hazard request (asynchronous level)
//   LEFT_LAMP   out  left bank, bit0 innermost, 1 = lit (registered)
//   RIGHT_LAMP  out  right bank, bit0 innermost, 1 = lit (registered)
//   BUSY        out  1 whenever the sequencer is not idle (registered)
//
// TICK_DIV is the number of clock cycles per sequence step (minimum 2).
module turn_signal_ctrl #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       SW_LEFT,
  input  logic       SW_RIGHT,
  input  logic       SW_HAZARD,
  output logic [2:0] LEFT_LAMP,
  output logic [2:0] RIGHT_LAMP,
  output logic       BUSY
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StL1, StL2, StL3, StLGap, StR1, StR2, StR3, StRGap, StHon, StHoff
  } state_e;

  // Two-stage synchronizers, bit order {hazard, right, left}
  logic [2:0] sync_q1;
  logic [2:0] sync_q2;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  state_e          state_q;
  state_e          state_d;
  logic [2:0]      left_q;
  logic [2:0]      right_q;
  logic            busy_q;

  logic sync_l;
  logic sync_r;
  logic sync_h;
  logic hz;
  logic tick;

  assign sync_l = sync_q2[0];
  assign sync_r = sync_q2[1];
  assign sync_h = sync_q2[2];
  // Both directions at once behave exactly like a hazard request
  assign hz     = sync_h | (sync_l & sync_r);
  assign tick   = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      // Idle exits are checked every cycle, not just on a tick
      if (hz) begin
        state_d = StHon;
      end else if (sync_l) begin
        state_d = StL1;
      end else if (sync_r) begin
        state_d = StR1;
      end
    end else if (tick) begin
      if (hz) begin
        state_d = (state_q == StHon) ? StHoff : StHon;
      end else begin
        case (state_q)
          StL1:    state_d = sync_l ? StL2   : StIdle;
          StL2:    state_d = sync_l ? StL3   : StIdle;
          StL3:    state_d = sync_l ? StLGap : StIdle;
          StLGap:  state_d = sync_l ? StL1   : StIdle;
          StR1:    state_d = sync_r ? StR2   : StIdle;
          StR2:    state_d = sync_r ? StR3   : StIdle;
          StR3:    state_d = sync_r ? StRGap : StIdle;
          StRGap:  state_d = sync_r ? StR1   : StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Counter sits at 0 in idle, so every idle exit starts a full step
  always_comb begin
    if (state_q == StIdle || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      left_q  <= '0;
      right_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      sync_q1 <= {SW_HAZARD, SW_RIGHT, SW_LEFT};
      sync_q2 <= sync_q1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      // Lamps are decoded from the next state so they change with the state register
      busy_q  <= (state_d != StIdle);
      case (state_d)
        StL1:    begin left_q <= 3'b001; right_q <= 3'b000; end
        StL2:    begin left_q <= 3'b011; right_q <= 3'b000; end
        StL3:    begin left_q <= 3'b111; right_q <= 3'b000; end
        StR1:    begin left_q <= 3'b000; right_q <= 3'b001; end
        StR2:    begin left_q <= 3'b000; right_q <= 3'b011; end
        StR3:    begin left_q <= 3'b000; right_q <= 3'b111; end
        StHon:   begin left_q <= 3'b111; right_q <= 3'b111; end
        default: begin left_q <= 3'b000; right_q <= 3'b000; end
      endcase
    end
  end

  assign LEFT_LAMP  = left_q;
  assign RIGHT_LAMP = right_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb_turn_signal_ctrl: directed and randomized bench for turn_signal_ctrl.
// A mode/phase reference model predicts lamps and BUSY on every cycle.
module tb_turn_signal_ctrl;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_l;
  logic       sw_r;
  logic       sw_h;
  logic [2:0] ll;
  logic [2:0] rl;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard.
  // phase: left/right 0..3 (3 is the gap), hazard 0 on / 1 off.
  int         m_mode;
  int         m_phase;
  int         m_timer;
  logic [2:0] m_s1;
  logic [2:0] m_s2;

  always #5 clk = ~clk;

  turn_signal_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .SW_LEFT   (sw_l),
    .SW_RIGHT  (sw_r),
    .SW_HAZARD (sw_h),
    .LEFT_LAMP (ll),
    .RIGHT_LAMP(rl),
    .BUSY      (busy)
  );

  function automatic logic [2:0] bar(input int p);
    if (p < 3) return 3'((1 << (p + 1)) - 1);
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_left();
    if (m_mode == 1) return bar(m_phase);
    if (m_mode == 3 && m_phase == 0) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_right();
    if (m_mode == 2) return bar(m_phase);
    if (m_mode == 3 && m_phase == 0) return 3'b111;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    m_timer = 0;
    m_s1    = 3'b000;
    m_s2    = 3'b000;
  endtask

  // Applied at each rising edge, using the inputs present at that edge
  task automatic model_edge();
    logic l, r, h, hz;
    {h, r, l} = m_s2;
    hz = h | (l & r);
    if (m_mode == 0) begin
      m_timer = 0;
      m_phase = 0;
      if (hz) m_mode = 3;
      else if (l) m_mode = 1;
      else if (r) m_mode = 2;
    end else if (m_timer == TD - 1) begin
      m_timer = 0;
      if (hz) begin
        if (m_mode == 3 && m_phase == 0) m_phase = 1;
        else begin
          m_mode  = 3;
          m_phase = 0;
        end
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if ((m_mode == 1 && l) || (m_mode == 2 && r)) begin
        m_phase = (m_phase + 1) % 4;
      end else begin
        m_mode = 0;
      end
    end else begin
      m_timer++;
    end
    m_s2 = m_s1;
    m_s1 = {sw_h, sw_r, sw_l};
  endtask

  task automatic check_model();
    chk("model_left", ll, exp_left());
    chk("model_right", rl, exp_right());
    chk("model_busy", {2'b00, busy}, {2'b00, m_mode != 0});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_left", ll, 3'b000);
    chk("rst_right", rl, 3'b000);
    chk("rst_busy", {2'b00, busy}, 3'b000);
    rst = 1'b0;
  endtask

  function automatic logic [2:0] obs(input int sel);
    if (sel == 0) return ll;
    if (sel == 1) return rl;
    return {2'b00, busy};
  endfunction

  // Bounded wait; an expired budget shows up as a failed comparison
  task automatic wait_for(input string tag, input int sel, input logic [2:0] v);
    int n;
    n = 0;
    while (obs(sel) !== v && n < 40) begin
      step();
      n++;
    end
    chk(tag, obs(sel), v);
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("arst_left", ll, 3'b000);
    chk("arst_right", rl, 3'b000);
    chk("arst_busy", {2'b00, busy}, 3'b000);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst  = 1'b1;
    sw_l = 1'b0;
    sw_r = 1'b0;
    sw_h = 1'b0;
    model_reset();

    // Left sequence from reset release
    sw_l = 1'b1;
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      step();
      case (c)
        2:  chk("left_c2", ll, 3'b000);
        3:  begin chk("left_c3", ll, 3'b001); chk("busy_c3", {2'b00, busy}, 3'b001); end
        7:  chk("left_c7", ll, 3'b011);
        11: chk("left_c11", ll, 3'b111);
        15: chk("left_c15", ll, 3'b000);
        19: chk("left_c19", ll, 3'b001);
        default: ;
      endcase
    end

    // Release mid-step in R2
    sw_l = 1'b0;
    sw_r = 1'b1;
    do_reset();
    wait_for("reach_r2", 1, 3'b011);
    sw_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r2_hold", rl, 3'b011);
    end
    step();
    chk("r2_drop_right", rl, 3'b000);
    chk("r2_drop_busy", {2'b00, busy}, 3'b000);
    repeat (4) step();
    chk("r2_stay_idle", {2'b00, busy}, 3'b000);

    // Hazard takes over from L2
    sw_l = 1'b1;
    do_reset();
    wait_for("reach_l2", 0, 3'b011);
    sw_h = 1'b1;
    repeat (3) step();
    chk("hz_l2_hold", ll, 3'b011);
    step();
    chk("hz_on_left", ll, 3'b111);
    chk("hz_on_right", rl, 3'b111);
    for (int k = 0; k < 4; k++) begin
      repeat (4) step();
      chk("hz_alt", rl, (k % 2 == 0) ? 3'b000 : 3'b111);
    end
    sw_h = 1'b0;
    sw_l = 1'b0;
    repeat (4) step();
    chk("hz_exit_busy", {2'b00, busy}, 3'b000);

    // Both directions behave as hazard
    sw_l = 1'b1;
    sw_r = 1'b1;
    do_reset();
    repeat (3) step();
    chk("both_left", ll, 3'b111);
    chk("both_right", rl, 3'b111);
    repeat (4) step();
    chk("both_off", ll, 3'b000);
    chk("both_off_busy", {2'b00, busy}, 3'b001);

    // Direction change from L3
    sw_r = 1'b0;
    do_reset();
    wait_for("reach_l3", 0, 3'b111);
    sw_l = 1'b0;
    sw_r = 1'b1;
    repeat (3) step();
    chk("dc_l3_hold", ll, 3'b111);
    step();
    chk("dc_idle_left", ll, 3'b000);
    chk("dc_idle_busy", {2'b00, busy}, 3'b000);
    step();
    chk("dc_r1", rl, 3'b001);

    // Asynchronous reset pulse during HON
    sw_r = 1'b0;
    sw_h = 1'b1;
    do_reset();
    repeat (3) step();
    chk("ar_hon", ll, 3'b111);
    repeat (2) step();
    async_reset_pulse();
    repeat (2) step();
    chk("ar_still_idle", {2'b00, busy}, 3'b000);
    step();
    chk("ar_hon_again", rl, 3'b111);
    repeat (3) step();
    chk("ar_hon_full_step", rl, 3'b111);
    step();
    chk("ar_hoff", rl, 3'b000);

    // Randomized switching with occasional asynchronous resets
    sw_h = 1'b0;
    sw_l = 1'b0;
    sw_r = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        sw_l = 1'($urandom_range(0, 1));
        sw_r = 1'($urandom_range(0, 1));
        sw_h = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 149) == 0) async_reset_pulse();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
